// File: rtl/pipe_share_arb_if.sv
// rtl/pipe_share_arb_if.sv - requester, shared-pipeline and result signals of pipe_share_arb
interface pipe_share_arb_if #(
    parameter int width  = 8,
    parameter int numReq = 4,
    parameter int tagW   = 2
);
    logic [numReq-1:0]       req_valid;
    logic [numReq*width-1:0] req_data;
    logic [numReq-1:0]       req_ready;
    logic                    pipe_ce;
    logic [width-1:0]        pipe_din;
    logic [width-1:0]        pipe_dout;
    logic                    out_valid;
    logic [width-1:0]        out_data;
    logic [tagW-1:0]         out_tag;
    logic                    out_ready;

    modport master (
        input  req_valid, req_data, pipe_dout, out_ready,
        output req_ready, pipe_ce, pipe_din, out_valid, out_data, out_tag
    );

    modport slave (
        output req_valid, req_data, pipe_dout, out_ready,
        input  req_ready, pipe_ce, pipe_din, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/pipe_share_arb.sv
// rtl/pipe_share_arb.sv - round-robin sharing of one ce-stalled pipeline among numReq requesters
module pipe_share_arb #(
    parameter int width        = 8,
    parameter int numPipeStage = 3,
    parameter int numReq       = 4,
    parameter int tagW         = 2,
    parameter int occW         = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    pipe_share_arb_if.master    bus,
    output logic [occW-1:0]     occupancy,
    output logic                busy
);
    localparam int LAST = numPipeStage - 1;

    logic [numPipeStage-1:0]           vld_q, vld_d;
    logic [numPipeStage-1:0][tagW-1:0] tag_q, tag_d;
    logic [tagW-1:0]                   rr_ptr_q, rr_ptr_d;
    logic [occW-1:0]                   occ_q, occ_d;

    logic            grant_any;
    logic [tagW-1:0] grant_idx;
    logic [tagW-1:0] cand_idx;
    logic            xfer;
    int              cand;

    assign bus.out_valid = vld_q[LAST];
    assign bus.out_tag   = tag_q[LAST];
    assign bus.out_data  = bus.pipe_dout;
    assign occupancy     = occ_q;
    assign busy          = (occ_q != '0);
    assign xfer          = vld_q[LAST] & bus.out_ready;

    // Search starts at rr_ptr and wraps explicitly, so non power-of-2 numReq stays in range.
    always_comb begin
        bus.pipe_ce   = ~(vld_q[LAST] & ~bus.out_ready) & ~rst;
        grant_any     = 1'b0;
        grant_idx     = '0;
        cand          = 0;
        cand_idx      = '0;
        bus.req_ready = '0;
        bus.pipe_din  = '0;
        if (bus.pipe_ce && !flush) begin
            for (int off = 0; off < numReq; off++) begin
                cand = int'(rr_ptr_q) + off;
                if (cand >= numReq) begin
                    cand = cand - numReq;
                end
                cand_idx = tagW'(cand);
                if (!grant_any && bus.req_valid[cand_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end
        for (int i = 0; i < numReq; i++) begin
            if (grant_any && grant_idx == tagW'(i)) begin
                bus.req_ready[i] = 1'b1;
                bus.pipe_din     = bus.req_data[i*width +: width];
            end
        end
    end

    always_comb begin
        vld_d    = vld_q;
        tag_d    = tag_q;
        rr_ptr_d = rr_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            vld_d = '0;
            occ_d = '0;
        end else if (bus.pipe_ce) begin
            vld_d[0] = grant_any;
            tag_d[0] = grant_any ? grant_idx : '0;
            for (int k = 1; k < numPipeStage; k++) begin
                vld_d[k] = vld_q[k-1];
                tag_d[k] = tag_q[k-1];
            end
            if (grant_any) begin
                rr_ptr_d = (grant_idx == tagW'(numReq - 1)) ? '0 : grant_idx + 1'b1;
            end
            occ_d = occ_q + occW'(grant_any) - occW'(xfer);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            tag_q    <= '0;
            rr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            vld_q    <= vld_d;
            tag_q    <= tag_d;
            rr_ptr_q <= rr_ptr_d;
            occ_q    <= occ_d;
        end
    end
endmodule

// File: doc/pipe_share_arb.md
Name: pipe_share_arb

Overview:
- Shares one p_mod-style pipeline among numReq requesters using round-robin arbitration.
- Drives the pipeline's ce and din, and tracks a valid bit and requester tag per stage alongside the data.
- Presents each result with its originating tag on a valid/ready output port.
- Stalls the whole pipeline (ce low) under downstream backpressure; sits between the requester blocks and the shared pipeline instance.

Parameters:
- width, 8, data width; must match the pipeline's width.
- numPipeStage, 3, pipeline depth in stages; must match the pipeline; >=1.
- numReq, 4, number of requesters; >=2.
- tagW, 2, tag width; must equal clog2(numReq).
- occW, 2, occupancy counter width; must equal clog2(numPipeStage+1).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high; also drives the pipeline's rst.
- flush  in  1  synchronous pipeline invalidate.
- req_valid  in  numReq  per-requester valid.
- req_data  in  numReq*width  requester i data at bits [i*width +: width].
- req_ready  out  numReq  one-hot grant; at most one bit high.
- pipe_ce  out  1  to pipeline ce.
- pipe_din  out  width  to pipeline din.
- pipe_dout  in  width  from pipeline dout.
- out_valid  out  1  result valid.
- out_data  out  width  result data; equals pipe_dout.
- out_tag  out  tagW  index of the requester that issued the result.
- out_ready  in  1  downstream accept.
- occupancy  out  occW  number of valid entries in flight.
- busy  out  1  high when occupancy != 0.

Behaviour:
- Internal state:
  - vld[numPipeStage-1:0] and tag[numPipeStage-1:0][tagW-1:0], mirroring the pipeline stages.
  - Round-robin pointer rr_ptr (tagW bits).
  - occupancy register.
- Reset (rst=1 at an edge): vld=0, tag=0, rr_ptr=0, occupancy=0.
  - Outputs during reset: out_valid=0, busy=0, occupancy=0.
  - req_ready=0 while rst is high.
  - rst has priority over flush and over all handshakes.
- Combinational outputs:
  - pipe_ce = ~(vld[last] & ~out_ready) & ~rst.
  - out_valid = vld[last]; out_tag = tag[last]; out_data = pipe_dout.
- Arbitration (combinational, only when pipe_ce=1 and flush=0):
  - Grant g is the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo numReq.
  - req_ready[g]=1; pipe_din = req_data[g].
  - With no grant: req_ready=0 and pipe_din=0.
  - req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
- Shift, on an edge with pipe_ce=1 and flush=0:
  - vld[0] <= grant_any; tag[0] <= g, or 0 when there is no grant.
  - vld[k] <= vld[k-1] and tag[k] <= tag[k-1] for k>=1.
- Pointer: rr_ptr <= g+1 mod numReq on a grant; unchanged otherwise.
- Stall (pipe_ce=0): vld, tag and rr_ptr hold; no grant is issued.
- Output transfer happens when out_valid & out_ready.
  - Because pipe_ce=1 whenever out_ready=1, the last stage advances in the same cycle.
- Latency: a request accepted in cycle N gives out_valid in cycle N+numPipeStage with no stalls; each stall cycle adds 1.
  - Full throughput is 1 result per cycle.
- Occupancy update each edge:
  - +1 on insert (grant).
  - -1 on output transfer.
  - Unchanged when both or neither occur.
  - Never exceeds numPipeStage and never underflows.
- Flush (rst=0, flush=1):
  - At the edge: vld <= 0, occupancy <= 0, rr_ptr holds.
  - During the flush cycle: no grant, req_ready=0.
  - out_valid still reflects vld[last] during the flush cycle. If out_ready=1 that cycle the transfer completes, but the entry is still cleared from occupancy.
  - Pipeline data registers are not cleared (don't-care under vld=0).
- Tag wrap: rr_ptr wraps from numReq-1 to 0.
- numReq that is not a power of 2: the modulo is explicit, and rr_ptr never holds a value >= numReq.

Test Plan:
- Reset then idle: rst high 2 cycles, all req_valid=0 -> out_valid=0, occupancy=0, pipe_ce=1, req_ready=0.
- Single request: req_valid=4'b0100, data 8'hA5 at cycle 0, out_ready=1 -> req_ready=4'b0100 at cycle 0; out_valid=1, out_data=8'hA5, out_tag=2 at cycle 3; occupancy 1,1,1,0 across cycles 1-4.
- Round-robin fairness: all four valid continuously, out_ready=1 -> grants in order 0,1,2,3,0,...; outputs from cycle 3 with tags 0,1,2,3; occupancy saturates at 3.
- Backpressure: stream from requester 1, out_ready=0 for cycles 5-7 -> pipe_ce=0 and req_ready=0 in cycles 5-7; out_data/out_tag held stable; no data lost or duplicated; order preserved after release.
- Flush mid-stream: 3 entries in flight, flush=1 in one cycle with out_ready=0 -> next cycle occupancy=0, out_valid=0; busy falls; new request thereafter arrives 3 cycles after grant.
- Reset mid-operation: rst asserted with occupancy=2 while out_valid=1 -> next cycle out_valid=0, occupancy=0, rr_ptr=0; first grant after rst release goes to requester 0 when all are valid.
